// File: rtl/uart_pkg.sv
// uart_pkg
// Shared definitions for the UART transmit arbiter slice.
//   arb_state_t             : arbiter FSM state encoding
//   TIMEOUT_CYCLES_DEFAULT  : default idle-lock timeout, only meaningful when
//                             the arbiter is built with UART_ARB_TIMEOUT_EN
package uart_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_LOCK  = 2'd1,
      S_FLUSH = 2'd2
   } arb_state_t;

   localparam int TIMEOUT_CYCLES_DEFAULT = 65535;

endpackage

// File: rtl/rr_pick.sv
// rr_pick
// Combinational round-robin picker: searches req starting at the index just
// after prev and wraps around, returning the first set bit.
// Ports:
//   req      : [N-1:0]     request vector
//   prev     : [IDX_W-1:0] index of the previous winner
//   pick     : [N-1:0]     one-hot winner, all-zero when req is empty
//   pick_idx : [IDX_W-1:0] binary index of the winner (prev when req empty)
module rr_pick #(
   parameter int N     = 2,
   parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] prev,
   output logic [N-1:0]     pick,
   output logic [IDX_W-1:0] pick_idx
);

   // Walk offsets from farthest to nearest so the nearest requester after
   // prev is the last one written and therefore wins.
   always_comb begin
      pick     = '0;
      pick_idx = prev;
      for (int off = N; off >= 1; off--) begin
         if (req[(int'(prev) + off) % N]) begin
            pick                            = '0;
            pick[(int'(prev) + off) % N]    = 1'b1;
            pick_idx                        = IDX_W'((int'(prev) + off) % N);
         end
      end
   end

endmodule

// File: rtl/uart_tx_arb.sv
// uart_tx_arb
// Shares one uart_tx byte interface between NUM_REQ requesters. A requester
// that wins round-robin arbitration keeps the grant for a whole message
// (until its req_last byte has been taken by the uart_tx). Bytes pass through
// a single holding register that drives tx_valid/tx_byte.
// Optional feature: define UART_ARB_TIMEOUT_EN to revoke a grant after
// TIMEOUT_CYCLES cycles in which the owner has nothing to send.
// Ports:
//   clk, rst_n             : clock, asynchronous active-low reset
//   req_valid/ready/last   : [NUM_REQ-1:0] per-requester handshake
//   req_data               : [8*NUM_REQ-1:0] requester i at [8i+7:8i]
//   tx_valid, tx_ready     : handshake towards uart_tx
//   tx_byte                : [7:0] byte towards uart_tx
//   grant                  : [NUM_REQ-1:0] one-hot owner, zero when unowned
//   busy                   : owner present or holding register full
module uart_tx_arb
   import uart_pkg::*;
#(
   parameter int NUM_REQ        = 2,
   parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NUM_REQ-1:0]   req_valid,
   output logic [NUM_REQ-1:0]   req_ready,
   input  logic [8*NUM_REQ-1:0] req_data,
   input  logic [NUM_REQ-1:0]   req_last,
   output logic                 tx_valid,
   input  logic                 tx_ready,
   output logic [7:0]           tx_byte,
   output logic [NUM_REQ-1:0]   grant,
   output logic                 busy
);

   localparam int IDX_W = $clog2(NUM_REQ);

   if (NUM_REQ < 2 || NUM_REQ > 4 || TIMEOUT_CYCLES < 1) begin : g_bad_params
      $error("uart_tx_arb: NUM_REQ must be 2..4 and TIMEOUT_CYCLES >= 1");
   end

   arb_state_t         state;
   logic [IDX_W-1:0]   rr_ptr;
   logic [NUM_REQ-1:0] rr_pick_oh;
   logic [IDX_W-1:0]   rr_pick_idx;
   logic               owner_valid;
   logic               owner_last;
   logic [7:0]         owner_data;

`ifdef UART_ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0]   idle_cnt;
`endif

   rr_pick #(
      .N     (NUM_REQ),
      .IDX_W (IDX_W)
   ) u_rr_pick (
      .req      (req_valid),
      .prev     (rr_ptr),
      .pick     (rr_pick_oh),
      .pick_idx (rr_pick_idx)
   );

   // Select the current owner's request lines; grant is one-hot so at most
   // one iteration contributes.
   always_comb begin
      owner_valid = 1'b0;
      owner_last  = 1'b0;
      owner_data  = 8'h00;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant[i]) begin
            owner_valid = req_valid[i];
            owner_last  = req_last[i];
            owner_data  = req_data[8*i +: 8];
         end
      end
   end

   // Only the owner may push, and only into an empty holding register.
   // Because ready looks at the current register contents, a byte can never
   // be loaded in the same cycle the register drains.
   assign req_ready = (state == S_LOCK && !tx_valid) ? grant : '0;
   assign busy      = (|grant) | tx_valid;

   // Arbiter FSM and holding register. tx_byte keeps its last value after
   // being consumed; only tx_valid marks it meaningful.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= S_IDLE;
         grant    <= '0;
         tx_valid <= 1'b0;
         tx_byte  <= 8'h00;
         rr_ptr   <= IDX_W'(NUM_REQ - 1);
`ifdef UART_ARB_TIMEOUT_EN
         idle_cnt <= '0;
`endif
      end else begin
         case (state)
            S_IDLE: begin
`ifdef UART_ARB_TIMEOUT_EN
               idle_cnt <= '0;
`endif
               if (|req_valid) begin
                  grant  <= rr_pick_oh;
                  rr_ptr <= rr_pick_idx;
                  state  <= S_LOCK;
               end
            end
            S_LOCK: begin
               if (tx_valid) begin
                  if (tx_ready) begin
                     tx_valid <= 1'b0;
                  end
               end else if (owner_valid) begin
                  tx_byte  <= owner_data;
                  tx_valid <= 1'b1;
`ifdef UART_ARB_TIMEOUT_EN
                  idle_cnt <= '0;
`endif
                  if (owner_last) begin
                     state <= S_FLUSH;
                  end
               end
`ifdef UART_ARB_TIMEOUT_EN
               else begin
                  if (idle_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                     idle_cnt <= '0;
                     grant    <= '0;
                     state    <= S_IDLE;
                  end else begin
                     idle_cnt <= idle_cnt + 1'b1;
                  end
               end
`endif
            end
            S_FLUSH: begin
               if (tx_valid && tx_ready) begin
                  tx_valid <= 1'b0;
                  grant    <= '0;
                  state    <= S_IDLE;
               end
            end
            default: begin
               state    <= S_IDLE;
               grant    <= '0;
               tx_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule
